fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core.
- Holds the PC and drives a variable-latency req/ack instruction-memory port.
- Presents fetched words to decode, whose opcode field [31:26] feeds R/I/J classification.
- Handles decode stalls, branch/jump redirects with MIPS delay-slot semantics, and full flush.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if_id_reg.sv | 61 ++++++
 rtl/fetch_stage.sv | 192 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// reset/bubble defaults and an address alignment helper.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load, otherwise hold.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    // Select next IF/ID contents: bubble, load a new word, or hold
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (bubble) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d    = instr_in;
            pc_d       = pc_in;
            pc_plus4_d = pc_in + 32'd4;
            valid_d    = 1'b1;
        end
    end

    // IF/ID state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= NOP_WORD;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, req/ack imem port, one-entry hold buffer,
// delay-slot redirect and flush with kill of an outstanding request.
// Optional performance counters enabled by defining FETCH_PERF_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic         tgt_pend_q, tgt_pend_d;
    logic         kill_q, kill_d;
    logic [31:0]  kill_addr_q, kill_addr_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  buf_pc_q, buf_pc_d;

    logic         ifid_load, ifid_bubble;
    logic [31:0]  ifid_instr, ifid_pc;
    logic [31:0]  seq_pc;

    // Next-state, PC sequencing, IF/ID control and imem request generation
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        tgt_pend_d  = tgt_pend_q;
        kill_d      = kill_q;
        kill_addr_d = kill_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_instr  = imem_rdata;
        ifid_pc     = pc_q;
        imem_req    = 1'b0;
        imem_addr   = pc_q;
        seq_pc      = tgt_pend_q ? tgt_q : (pc_q + 32'd4);

        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
                if (redirect) begin
                    tgt_d      = word_align(redirect_pc);
                    tgt_pend_d = 1'b1;
                end
            end
            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = kill_q ? kill_addr_q : pc_q;
                if (kill_q) begin
                    // Squashed request: drop the word once memory answers
                    if (imem_ack) kill_d = 1'b0;
                end else if (imem_ack) begin
                    pc_d       = redirect ? word_align(redirect_pc) : seq_pc;
                    tgt_pend_d = 1'b0;
                    if (stall) begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = pc_q;
                        state_d     = S_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end else if (redirect) begin
                    tgt_d      = word_align(redirect_pc);
                    tgt_pend_d = 1'b1;
                end
                if (!ifid_load && !stall) ifid_bubble = 1'b1;
            end
            S_HOLD: begin
                if (!stall) begin
                    ifid_load  = 1'b1;
                    ifid_instr = buf_instr_q;
                    ifid_pc    = buf_pc_q;
                    state_d    = S_REQ;
                end
                // The buffered word is the delay slot and pc already points
                // past it, so the target replaces the next fetch address.
                if (redirect) begin
                    pc_d       = word_align(redirect_pc);
                    tgt_pend_d = 1'b0;
                end
            end
            default: state_d = S_BOOT;
        endcase

        if (flush) begin
            pc_d        = word_align(flush_pc);
            tgt_pend_d  = 1'b0;
            ifid_load   = 1'b0;
            ifid_bubble = 1'b1;
            state_d     = S_REQ;
            if (state_q == S_REQ && !imem_ack) begin
                kill_d = 1'b1;
                if (!kill_q) kill_addr_d = pc_q;
            end else begin
                kill_d = 1'b0;
            end
        end
    end

    // Fetch state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            tgt_q       <= '0;
            tgt_pend_q  <= 1'b0;
            kill_q      <= 1'b0;
            kill_addr_q <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            tgt_pend_q  <= tgt_pend_d;
            kill_q      <= kill_d;
            kill_addr_q <= kill_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    if_id_reg #(
        .NOP_WORD(NOP_WORD)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .instr_in (ifid_instr),
        .pc_in    (ifid_pc),
        .instr    (if_id_instr),
        .pc       (if_id_pc),
        .pc_plus4 (if_id_pc_plus4),
        .valid    (if_id_valid)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Count non-discarded fetches and cycles lost to stall or memory wait
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (state_q == S_REQ && imem_ack && !kill_q && !flush)
            perf_fetched_d = perf_fetched_q + 32'd1;
        if (stall || (imem_req && !imem_ack))
            perf_stall_d = perf_stall_q + 32'd1;
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched      = perf_fetched_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, async reset
// sequence, then randomized stall/ack/redirect/flush against a program-order
// reference model.
module tb_fetch_stage;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, flush, imem_ack;
    logic [31:0] redirect_pc, flush_pc, imem_rdata;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall_cycles;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC(BASE),
        .NOP_WORD(NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        st, ack, rd, fl;
        logic [31:0] rpc, fpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic ack, input logic rd, input logic fl,
                                input logic [31:0] rpc, input logic [31:0] fpc,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic evalid, input logic [31:0] epc);
        vec_t v;
        v = '{st, ack, rd, fl, rpc, fpc, ereq, eaddr, evalid, epc};
        return v;
    endfunction

    localparam int NV = 18;
    vec_t tbl[NV];

    // random-phase reference model state
    logic [31:0] exp_pc, slot_tgt, prev_addr, xor_k, tgt_raw;
    logic        after_slot, prev_pend, flush_chk, armed;
    logic        st_r, fl_r, rd_r, ack_r, consume;
    int unsigned wait_left, consumed;

    initial begin
        // stall, ack, redirect, flush, rpc, fpc | req, addr, valid, pc
        tbl[0]  = mk(0,0,0,0, 0, 0,                    0, 0,            0, 0);
        tbl[1]  = mk(0,1,0,0, 0, 0,                    1, BASE,         0, 0);
        tbl[2]  = mk(0,1,0,0, 0, 0,                    1, BASE+32'h4,   1, BASE);
        tbl[3]  = mk(1,1,0,0, 0, 0,                    1, BASE+32'h8,   1, BASE+32'h4);
        tbl[4]  = mk(1,0,0,0, 0, 0,                    0, 0,            1, BASE+32'h4);
        tbl[5]  = mk(1,0,0,0, 0, 0,                    0, 0,            1, BASE+32'h4);
        tbl[6]  = mk(0,0,0,0, 0, 0,                    0, 0,            1, BASE+32'h4);
        tbl[7]  = mk(0,0,0,0, 0, 0,                    1, BASE+32'hC,   1, BASE+32'h8);
        tbl[8]  = mk(0,1,0,0, 0, 0,                    1, BASE+32'hC,   0, 0);
        tbl[9]  = mk(0,0,0,0, 0, 0,                    1, BASE+32'h10,  1, BASE+32'hC);
        tbl[10] = mk(0,0,1,0, BASE+32'h101, 0,         1, BASE+32'h10,  0, 0);
        tbl[11] = mk(0,0,0,0, 0, 0,                    1, BASE+32'h10,  0, 0);
        tbl[12] = mk(0,1,0,0, 0, 0,                    1, BASE+32'h10,  0, 0);
        tbl[13] = mk(0,0,0,1, 0, 32'h8000_0182,        1, BASE+32'h100, 1, BASE+32'h10);
        tbl[14] = mk(0,0,0,0, 0, 0,                    1, BASE+32'h100, 0, 0);
        tbl[15] = mk(0,1,0,0, 0, 0,                    1, BASE+32'h100, 0, 0);
        tbl[16] = mk(0,1,0,0, 0, 0,                    1, 32'h8000_0180, 0, 0);
        tbl[17] = mk(0,1,0,0, 0, 0,                    1, 32'h8000_0184, 1, 32'h8000_0180);

        rst = 1'b1; stall = 0; redirect = 0; flush = 0; imem_ack = 0;
        redirect_pc = '0; flush_pc = '0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // directed table: memory returns address as data
        for (int unsigned i = 0; i < NV; i++) begin
            chk($sformatf("t%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].exp_req});
            if (tbl[i].exp_req)
                chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].exp_addr);
            chk($sformatf("t%0d_valid", i), {31'b0, if_id_valid}, {31'b0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) begin
                chk($sformatf("t%0d_pc", i), if_id_pc, tbl[i].exp_pc);
                chk($sformatf("t%0d_instr", i), if_id_instr, tbl[i].exp_pc);
                chk($sformatf("t%0d_pc4", i), if_id_pc_plus4, tbl[i].exp_pc + 32'd4);
            end else begin
                chk($sformatf("t%0d_nop", i), if_id_instr, NOP);
            end
            stall       = tbl[i].st;
            imem_ack    = tbl[i].ack;
            imem_rdata  = tbl[i].ack ? imem_addr : 32'hDEAD_BEEF;
            redirect    = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
            flush       = tbl[i].fl;
            flush_pc    = tbl[i].fpc;
            @(posedge clk);
            #1;
        end

        // state before async reset: valid entry 0x80000184 in IF/ID
        chk("pre_rst_valid", {31'b0, if_id_valid}, 32'd1);
        chk("pre_rst_pc", if_id_pc, 32'h8000_0184);
        stall = 0; imem_ack = 0; redirect = 0; flush = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_valid", {31'b0, if_id_valid}, 32'd0);
        chk("arst_instr", if_id_instr, NOP);
        chk("arst_pc", if_id_pc, 32'd0);
        chk("arst_pc4", if_id_pc_plus4, 32'd0);
        #4 rst = 1'b0;
        #1;
        chk("boot_req", {31'b0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, BASE);

        // randomized phase
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        xor_k = 32'hC3C3_0F0F;
        exp_pc = BASE; after_slot = 0; slot_tgt = '0;
        prev_pend = 0; prev_addr = '0; flush_chk = 0; armed = 0;
        wait_left = 0; consumed = 0;
        for (int unsigned c = 0; c < 4000; c++) begin
            if (flush_chk) chk("flush_bubble", {31'b0, if_id_valid}, 32'd0);
            flush_chk = 0;
            if (prev_pend) begin
                chk("addr_hold_req", {31'b0, imem_req}, 32'd1);
                chk("addr_hold", imem_addr, prev_addr);
            end
            if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);

            st_r    = ($urandom % 4) == 0;
            fl_r    = ($urandom % 50) == 0;
            consume = if_id_valid && !st_r && !fl_r;
            rd_r    = consume && !after_slot && (($urandom % 5) == 0);
            tgt_raw = BASE + 32'h1000 + ($urandom % 1024) * 4 + ($urandom % 4);

            if (consume) begin
                chk("rand_pc", if_id_pc, exp_pc);
                chk("rand_instr", if_id_instr, exp_pc ^ xor_k);
                chk("rand_pc4", if_id_pc_plus4, exp_pc + 32'd4);
                consumed++;
                if (after_slot) begin
                    exp_pc = slot_tgt;
                    after_slot = 0;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
                if (rd_r) begin
                    slot_tgt = {tgt_raw[31:2], 2'b00};
                    after_slot = 1;
                end
            end

            flush_pc = 32'h8000_0000 + ($urandom % 1024) * 4 + ($urandom % 4);
            if (fl_r) begin
                exp_pc = {flush_pc[31:2], 2'b00};
                after_slot = 0;
                flush_chk = 1;
            end

            ack_r = 0;
            if (imem_req) begin
                if (!armed) begin
                    wait_left = ($urandom % 2) ? 0 : $urandom_range(1, 3);
                    armed = 1;
                end
                if (wait_left == 0) begin
                    ack_r = 1;
                    armed = 0;
                end else begin
                    wait_left--;
                end
            end else begin
                armed = 0;
            end
            prev_pend = imem_req && !ack_r;
            prev_addr = imem_addr;

            stall       = st_r;
            flush       = fl_r;
            redirect    = rd_r;
            redirect_pc = tgt_raw;
            imem_ack    = ack_r;
            imem_rdata  = ack_r ? (imem_addr ^ xor_k) : 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
        end
        chk("progress", {31'b0, consumed > 500}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
